ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Consumes bytes from the ps2_keyboard receive FIFO (data/ready/rdn/overflow) and decodes PS/2
//  set-2 scan codes, including E0 (extended) and F0 (break) prefixes, into key events.
//  Maintains a held-key bitmap and one-cycle press pulses for the 8 game keys.
//  Outputs feed the key/direction inputs of objectMotion and the game control logic.
//  Runs on the same clock as ps2_keyboard (Div[0]).
// PARAMETERS
//  TIMEOUT_CYCLES  5_000_000  cycles allowed after a prefix before it is discarded (100 ms @ 50 MHz)
//  TCNT_W          23         width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1  system clock, same clock as ps2_keyboard
//  rst          in   1  asynchronous reset, active-high
//  ps_data      in   8  FIFO head byte from ps2_keyboard.data; valid while ps_ready=1
//  ps_ready     in   1  FIFO non-empty (ps2_keyboard.ready)
//  ps_overflow  in   1  FIFO overflow flag (ps2_keyboard.overflow)
//  ps_rdn       out  1  active-low pop strobe to ps2_keyboard.rdn
//  key_valid    out  1  one-cycle pulse; key_code/key_ext/key_release valid in that cycle
//  key_code     out  8  final (non-prefix) scan-code byte
//  key_ext      out  1  event was preceded by E0
//  key_release  out  1  event was preceded by F0 (break)
//  key_held     out  8  level bitmap: [0]L-arrow E0 6B [1]R-arrow E0 74 [2]U-arrow E0 75
//                       [3]D-arrow E0 72 [4]space 29 [5]W 1D [6]A 1C [7]D 23
//  key_press    out  8  one-cycle pulse per bit on a key_held 0->1 edge
//  ovf_sticky   out  1  set when ps_overflow is seen; cleared only by rst
// BEHAVIOUR
//  Reset (async, rst=1): ps_rdn=1, all other outputs 0, FSM=IDLE, ext/brk flags 0, counter 0.
//  FSM states: IDLE, POP, SETTLE.
//   IDLE: if ps_ready=1 -> latch ps_data into byte_r, drive ps_rdn=0 for this one cycle, go POP.
//   POP: ps_rdn=1; process byte_r (below); go SETTLE.
//   SETTLE: one dead cycle so ps_ready reflects the pop; go IDLE.
//   ps_rdn is low exactly one cycle per byte; max throughput = 1 byte / 3 cycles.
//  Byte processing (in POP):
//   E0 -> ext=1; F0 -> brk=1; no event, timeout counter reloaded.
//   AA, FA, EE, FE (BAT/ack/echo/resend) -> ignored, ext and brk cleared, no event.
//   Any other byte -> key_valid=1 on the next cycle (SETTLE), with key_code=byte_r, key_ext=ext,
//   key_release=brk; ext and brk cleared.
//   Event-to-key_valid latency: 2 cycles after the ps_rdn=0 cycle.
//  key_code/key_ext/key_release hold their last values between pulses.
//  Held bitmap: an event matching a table entry (code and ext must both match) sets its bit on
//   make and clears it on break. Bitmap updates in the same cycle as key_valid.
//   A make for an already-held key (typematic repeat) pulses key_valid but not key_press.
//   A break for a key not held leaves the bitmap unchanged.
//  key_press[i] = key_held[i] rising edge; same cycle as the key_held update.
//  Timeout: while ext|brk=1 and no byte is processed, the counter increments each cycle.
//   When it reaches TIMEOUT_CYCLES-1, ext and brk clear and the counter returns to 0.
//   The counter is held at 0 while ext=brk=0.
//  Overflow: ps_overflow=1 in any cycle sets ovf_sticky and clears key_held, ext and brk.
//   It does not generate key_press or key_valid. If this coincides with a POP-cycle bitmap
//   update, the clear takes priority. FSM sequencing is unaffected.
//  Sequences F0 E0 xx and E0 F0 xx are both accepted as extended break.
//  Reset mid-sequence drops partial prefixes; ps_rdn returns to 1 immediately.
// TESTING
//  rst pulse mid-POP -> ps_rdn=1, key_held=0, key_valid=0 asynchronously; next byte decodes cleanly.
//  FIFO bytes 1D, F0 1D -> key_valid x2: (1D,ext0,rel0), (1D,ext0,rel1).
//   Result: key_held[5] 0->1->0, key_press[5] pulses once; exactly 3 single-cycle ps_rdn lows.
//  Bytes E0 74 then E0 74 (repeat) then E0 F0 74 -> key_held[1]=1 after the first,
//   key_press[1] pulses once only, key_held[1]=0 after the break; key_ext=1 on all events.
//  Byte E0, then idle for TIMEOUT_CYCLES (set to 16) + 2 cycles, then 29.
//   Result: event (29,ext0,rel0), key_held[4]=1, key_held[0..3] unchanged.
//  Bytes 6B (no E0) then FA then F0 AA -> key_valid once (6B,ext0), key_held=0 throughout;
//   after AA the brk flag is cleared.
//  Hold bits 0 and 4, then pulse ps_overflow for 1 cycle.
//   Result: key_held=0 next cycle, ovf_sticky=1 until rst, no key_press pulses.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops bytes from the ps2_keyboard receive FIFO and decodes
// PS/2 set-2 scan codes into key events. It handles the E0 (extended) and
// F0 (break) prefixes and keeps a held-key bitmap plus press pulses for the
// eight game keys.
//
// Ports
//   clk, rst        system clock (same as ps2_keyboard), async active-high reset
//   ps_data         FIFO head byte, valid while ps_ready=1
//   ps_ready        FIFO non-empty
//   ps_overflow     FIFO overflow flag
//   ps_rdn          active-low pop strobe, low for exactly one cycle per byte
//   key_valid       one-cycle event pulse qualifying key_code/key_ext/key_release
//   key_code        final (non-prefix) scan-code byte of the last event
//   key_ext         last event was preceded by E0
//   key_release     last event was preceded by F0
//   key_held        level bitmap: [0]L E0 6B [1]R E0 74 [2]U E0 75 [3]D E0 72
//                   [4]space 29 [5]W 1D [6]A 1C [7]D 23
//   key_press       one-cycle pulse on each key_held 0->1 edge
//   ovf_sticky      FIFO overflow seen since reset
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned TCNT_W         = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps_data,
  input  logic       ps_ready,
  input  logic       ps_overflow,
  output logic       ps_rdn,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic [7:0] key_held,
  output logic [7:0] key_press,
  output logic       ovf_sticky
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KEY_N  = 8;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic              pop_c;
  logic              proc_c;
  logic [BYTE_W-1:0] byte_r;
  logic              ext_r;
  logic              brk_r;
  logic [TCNT_W-1:0] tcnt_r;

  logic              is_ext_c;
  logic              is_brk_c;
  logic              is_ctl_c;
  logic              is_key_c;
  logic [KEY_N-1:0]  hit_c;
  logic [KEY_N-1:0]  held_upd_c;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one pop, one processing cycle, one dead cycle per byte
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ps_ready) state_d = POP;
      POP:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the pop strobe is gated by rst so it reads high during reset
  always_comb begin
    pop_c  = 1'b0;
    proc_c = 1'b0;
    case (state_q)
      IDLE:    pop_c  = ps_ready & ~rst;
      POP:     proc_c = 1'b1;
      default: ;
    endcase
  end

  assign ps_rdn = ~pop_c;

  // Byte classification and game-key lookup (code and ext must both match)
  always_comb begin
    is_ext_c = (byte_r == 8'hE0);
    is_brk_c = (byte_r == 8'hF0);
    is_ctl_c = byte_r inside {8'hAA, 8'hFA, 8'hEE, 8'hFE};
    is_key_c = proc_c & ~is_ext_c & ~is_brk_c & ~is_ctl_c;
    hit_c    = '0;
    case ({ext_r, byte_r})
      {1'b1, 8'h6B}: hit_c[0] = 1'b1;
      {1'b1, 8'h74}: hit_c[1] = 1'b1;
      {1'b1, 8'h75}: hit_c[2] = 1'b1;
      {1'b1, 8'h72}: hit_c[3] = 1'b1;
      {1'b0, 8'h29}: hit_c[4] = 1'b1;
      {1'b0, 8'h1D}: hit_c[5] = 1'b1;
      {1'b0, 8'h1C}: hit_c[6] = 1'b1;
      {1'b0, 8'h23}: hit_c[7] = 1'b1;
      default:       hit_c    = '0;
    endcase
    held_upd_c = brk_r ? (key_held & ~hit_c) : (key_held | hit_c);
  end

  // Byte latch, prefix flags, timeout counter, event and bitmap registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_r      <= '0;
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
      tcnt_r      <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_held    <= '0;
      key_press   <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_press <= '0;

      if (pop_c) begin
        byte_r <= ps_data;
      end

      if (is_key_c) begin
        key_valid   <= 1'b1;
        key_code    <= byte_r;
        key_ext     <= ext_r;
        key_release <= brk_r;
      end

      // A processed byte restarts the timeout; a lone prefix expires after
      // TIMEOUT_CYCLES idle cycles so a lost byte cannot poison later keys.
      if (proc_c) begin
        tcnt_r <= '0;
        if (is_ext_c) begin
          ext_r <= 1'b1;
        end else if (is_brk_c) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      end else if (ext_r | brk_r) begin
        if (tcnt_r == TCNT_LAST) begin
          ext_r  <= 1'b0;
          brk_r  <= 1'b0;
          tcnt_r <= '0;
        end else begin
          tcnt_r <= tcnt_r + TCNT_W'(1);
        end
      end else begin
        tcnt_r <= '0;
      end

      // Overflow means bytes were lost, so held state and prefixes are stale
      if (ps_overflow) begin
        ovf_sticky <= 1'b1;
        key_held   <= '0;
        ext_r      <= 1'b0;
        brk_r      <= 1'b0;
        tcnt_r     <= '0;
      end else if (is_key_c) begin
        key_held  <= held_upd_c;
        key_press <= held_upd_c & ~key_held;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: FIFO model, table vectors, directed corner
// sequences and a randomized byte stream against a byte-level reference model.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps_data = 8'h00;
  logic       ps_ready = 1'b0;
  logic       ps_overflow = 1'b0;
  logic       ps_rdn;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic [7:0] key_held;
  logic [7:0] key_press;
  logic       ovf_sticky;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .TCNT_W(5)) dut (
    .clk(clk), .rst(rst), .ps_data(ps_data), .ps_ready(ps_ready),
    .ps_overflow(ps_overflow), .ps_rdn(ps_rdn), .key_valid(key_valid),
    .key_code(key_code), .key_ext(key_ext), .key_release(key_release),
    .key_held(key_held), .key_press(key_press), .ovf_sticky(ovf_sticky)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] held;
    logic [7:0] press;
  } ev_t;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    bit         has_ev;
    ev_t        ev;
  } vec_t;

  logic [7:0] key_tbl_code [8] = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h1D, 8'h1C, 8'h23};
  bit         key_tbl_ext  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] ctl_tbl      [4] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE};

  logic [7:0] fifo_q [$];
  ev_t        obs_q  [$];
  ev_t        exp_q  [$];
  ev_t        mon_e;
  vec_t       tbl    [18];

  int n_vec = 0;
  int n_bad = 0;
  int total_pushed = 0;
  int rdn_lows = 0;
  int rdn_double = 0;
  bit pop_pending = 1'b0;
  bit rdn_prev_low = 1'b0;

  bit         m_ext;
  bit         m_brk;
  logic [7:0] m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO model and output monitor, both working on the falling edge
  always @(negedge clk) begin
    if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
    pop_pending = 1'b0;
    if (fifo_q.size() > 0) begin
      ps_ready = 1'b1;
      ps_data  = fifo_q[0];
    end else begin
      ps_ready = 1'b0;
      ps_data  = 8'h00;
    end
    #1;
    if (!ps_rdn) begin
      pop_pending = 1'b1;
      rdn_lows++;
      if (rdn_prev_low) rdn_double++;
    end
    rdn_prev_low = !ps_rdn;
    if (key_valid) begin
      mon_e.code  = key_code;
      mon_e.ext   = key_ext;
      mon_e.rel   = key_release;
      mon_e.held  = key_held;
      mon_e.press = key_press;
      obs_q.push_back(mon_e);
    end else begin
      check("press without valid", 32'(key_press), 32'h0);
    end
  end

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input bit h, input logic [7:0] c,
                              input bit e, input bit r, input logic [7:0] hd,
                              input logic [7:0] pr);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.has_ev = h;
    v.ev.code = c; v.ev.ext = e; v.ev.rel = r; v.ev.held = hd; v.ev.press = pr;
    return v;
  endfunction

  function automatic int key_index(input logic [7:0] c, input bit e);
    for (int i = 0; i < 8; i++) begin
      if (key_tbl_code[i] == c && key_tbl_ext[i] == e) return i;
    end
    return -1;
  endfunction

  // Reference: walk the byte stream applying the prefix/event/bitmap rules
  task automatic model_byte(input logic [7:0] b);
    int  k;
    ev_t e;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      e.press = 8'h00;
      k = key_index(b, m_ext);
      if (k >= 0) begin
        if (m_brk) m_held[k] = 1'b0;
        else begin
          if (!m_held[k]) e.press[k] = 1'b1;
          m_held[k] = 1'b1;
        end
      end
      e.code = b; e.ext = m_ext; e.rel = m_brk; e.held = m_held;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    total_pushed++;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    obs_q.delete();
    if (v.n > 0) push(v.b0);
    if (v.n > 1) push(v.b1);
    if (v.n > 2) push(v.b2);
    tick(3 * v.n + 6);
    check({name, " count"}, 32'(obs_q.size()), v.has_ev ? 32'd1 : 32'd0);
    if (v.has_ev && obs_q.size() > 0) check({name, " event"}, 32'(obs_q[0]), 32'(v.ev));
  endtask

  initial begin
    bit         found;
    logic [7:0] b;
    int         r;
    int         nrand;

    //           n  b0     b1     b2     ev code   ext rel held   press
    tbl[0]  = mk(1, 8'h1D, 8'h00, 8'h00, 1, 8'h1D, 0, 0, 8'h20, 8'h20);
    tbl[1]  = mk(2, 8'hF0, 8'h1D, 8'h00, 1, 8'h1D, 0, 1, 8'h00, 8'h00);
    tbl[2]  = mk(2, 8'hE0, 8'h74, 8'h00, 1, 8'h74, 1, 0, 8'h02, 8'h02);
    tbl[3]  = mk(2, 8'hE0, 8'h74, 8'h00, 1, 8'h74, 1, 0, 8'h02, 8'h00);
    tbl[4]  = mk(3, 8'hE0, 8'hF0, 8'h74, 1, 8'h74, 1, 1, 8'h00, 8'h00);
    tbl[5]  = mk(1, 8'h6B, 8'h00, 8'h00, 1, 8'h6B, 0, 0, 8'h00, 8'h00);
    tbl[6]  = mk(1, 8'hFA, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[7]  = mk(2, 8'hF0, 8'hAA, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[8]  = mk(2, 8'hE0, 8'h6B, 8'h00, 1, 8'h6B, 1, 0, 8'h01, 8'h01);
    tbl[9]  = mk(1, 8'h29, 8'h00, 8'h00, 1, 8'h29, 0, 0, 8'h11, 8'h10);
    tbl[10] = mk(3, 8'hF0, 8'hE0, 8'h6B, 1, 8'h6B, 1, 1, 8'h10, 8'h00);
    tbl[11] = mk(2, 8'hF0, 8'h23, 8'h00, 1, 8'h23, 0, 1, 8'h10, 8'h00);
    tbl[12] = mk(1, 8'h1C, 8'h00, 8'h00, 1, 8'h1C, 0, 0, 8'h50, 8'h40);
    tbl[13] = mk(2, 8'hE0, 8'h29, 8'h00, 1, 8'h29, 1, 0, 8'h50, 8'h00);
    tbl[14] = mk(2, 8'hE0, 8'h75, 8'h00, 1, 8'h75, 1, 0, 8'h54, 8'h04);
    tbl[15] = mk(2, 8'hE0, 8'h72, 8'h00, 1, 8'h72, 1, 0, 8'h5C, 8'h08);
    tbl[16] = mk(1, 8'h23, 8'h00, 8'h00, 1, 8'h23, 0, 0, 8'hDC, 8'h80);
    tbl[17] = mk(2, 8'hF0, 8'h1C, 8'h00, 1, 8'h1C, 0, 1, 8'h9C, 8'h00);

    // Reset values
    tick(2);
    check("rst ps_rdn", 32'(ps_rdn), 32'd1);
    check("rst key_valid", 32'(key_valid), 32'd0);
    check("rst key_code", 32'(key_code), 32'd0);
    check("rst key_ext/rel", 32'({key_ext, key_release}), 32'd0);
    check("rst key_held", 32'(key_held), 32'd0);
    check("rst key_press", 32'(key_press), 32'd0);
    check("rst ovf_sticky", 32'(ovf_sticky), 32'd0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 18; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Prefix survives an idle gap shorter than the timeout
    obs_q.delete();
    push(8'hE0);
    tick(4 + 8);
    push(8'h6B);
    tick(9);
    check("short gap count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0)
      check("short gap event", 32'(obs_q[0]), 32'({8'h6B, 1'b1, 1'b0, 8'h9D, 8'h01}));

    // Prefix discarded after the timeout
    obs_q.delete();
    push(8'hE0);
    tick(4 + TO + 2);
    push(8'h29);
    tick(9);
    check("timeout count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0)
      check("timeout event", 32'(obs_q[0]), 32'({8'h29, 1'b0, 1'b0, 8'h9D, 8'h00}));
    check("timeout arrows kept", 32'(key_held[3:0]), 32'h0D);

    // Overflow clears held bits and is sticky
    ps_overflow = 1'b1;
    tick(1);
    ps_overflow = 1'b0;
    check("ovf held cleared", 32'(key_held), 32'd0);
    check("ovf sticky set", 32'(ovf_sticky), 32'd1);
    tick(5);
    check("ovf sticky holds", 32'(ovf_sticky), 32'd1);

    // Overflow also drops a pending E0
    push(8'hE0);
    tick(5);
    ps_overflow = 1'b1;
    tick(1);
    ps_overflow = 1'b0;
    obs_q.delete();
    push(8'h1D);
    tick(9);
    check("ovf prefix count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0)
      check("ovf prefix event", 32'(obs_q[0]), 32'({8'h1D, 1'b0, 1'b0, 8'h20, 8'h20}));

    // Reset asserted in the POP cycle
    obs_q.delete();
    push(8'h29);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #2;
      if (!ps_rdn) found = 1'b1;
    end
    check("rst-pop strobe seen", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midpop ps_rdn", 32'(ps_rdn), 32'd1);
    check("midpop key_held", 32'(key_held), 32'd0);
    check("midpop key_valid", 32'(key_valid), 32'd0);
    check("midpop ovf_sticky", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    tick(4);
    check("midpop no event", 32'(obs_q.size()), 32'd0);
    apply_vec(mk(1, 8'h1D, 8'h00, 8'h00, 1, 8'h1D, 0, 0, 8'h20, 8'h20), "post-rst");

    // Randomized continuous stream against the reference model
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_held = 8'h00;
    obs_q.delete();
    exp_q.delete();
    nrand = 300;
    for (int k = 0; k < nrand; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    b = 8'hE0;
        2:       b = 8'hF0;
        3:       b = ctl_tbl[$urandom_range(0, 3)];
        9:       b = 8'($urandom_range(0, 255));
        default: b = key_tbl_code[$urandom_range(0, 7)];
      endcase
      model_byte(b);
      push(b);
    end
    tick(3 * nrand + 20);
    check("rand count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check($sformatf("rand ev%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
    check("rand final held", 32'(key_held), 32'(m_held));

    // Pop strobe bookkeeping over the whole run
    check("fifo drained", 32'(fifo_q.size()), 32'd0);
    check("rdn lows per byte", 32'(rdn_lows), 32'(total_pushed));
    check("rdn never 2 cycles", 32'(rdn_double), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
